// File: rtl/wb_ksa_responder.sv
// rtl/wb_ksa_responder.sv - Wishbone responder around a pipelined Kogge-Stone adder
// Operands and control are loaded by register writes; sum/carry read back from RESULT.
module wb_ksa_responder #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          WIDTH    = 16,
    parameter int          LAT      = $clog2(WIDTH) + 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);
    localparam int LOGW = $clog2(WIDTH);
    localparam int CW   = $clog2(LAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic              cin_q, cin_d, ie_q, ie_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [WIDTH:0]    result_q, result_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;

    logic [WIDTH-1:0]  in_a_q, in_a_d, in_b_q, in_b_d;
    logic              in_cin_q, in_cin_d;
    logic [LOGW:0][WIDTH-1:0] g_q, g_d, p_q, p_d, x_q, x_d;
    logic [LOGW:0]     c_q, c_d;
    logic [WIDTH:0]    sum_q, sum_d;

    logic              hit, req, wr, start, clr;
    logic [2:0]        off;
    logic [31:0]       wmask, rdata;

    // Free-running pipeline; the FSM counter decides when its output is meaningful.
    always_comb begin
        g_d[0]    = in_a_q & in_b_q;
        g_d[0][0] = (in_a_q[0] & in_b_q[0]) | ((in_a_q[0] ^ in_b_q[0]) & in_cin_q);
        p_d[0]    = in_a_q ^ in_b_q;
        x_d[0]    = in_a_q ^ in_b_q;
        c_d[0]    = in_cin_q;
        for (int k = 1; k <= LOGW; k++) begin
            g_d[k] = g_q[k-1];
            p_d[k] = p_q[k-1];
            x_d[k] = x_q[k-1];
            c_d[k] = c_q[k-1];
            for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
                g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-(1<<(k-1))]);
                p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-(1<<(k-1))];
            end
        end
        sum_d = {g_q[LOGW][WIDTH-1], x_q[LOGW] ^ {g_q[LOGW][WIDTH-2:0], c_q[LOGW]}};
    end

    always_comb begin
        hit   = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
        req   = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
        wr    = req & wbs_we_i;
        off   = wbs_adr_i[4:2];
        wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
        start = wr & (off == 3'd2) & wbs_sel_i[0] & wbs_dat_i[0];
        clr   = wr & (off == 3'd3) & wbs_sel_i[0];

        case (off)
            3'd0:    rdata = 32'(opa_q);
            3'd1:    rdata = 32'(opb_q);
            3'd2:    rdata = {29'd0, ie_q, cin_q, 1'b0};
            3'd3:    rdata = {29'd0, err_q, done_q, busy_q};
            3'd4:    rdata = 32'(result_q);
            default: rdata = 32'd0;
        endcase

        ack_d = req;
        dat_d = (req & ~wbs_we_i) ? rdata : 32'd0;

        opa_d = opa_q;
        opb_d = opb_q;
        cin_d = cin_q;
        ie_d  = ie_q;
        if (wr && off == 3'd0)
            opa_d = (opa_q & ~wmask[WIDTH-1:0]) | (wbs_dat_i[WIDTH-1:0] & wmask[WIDTH-1:0]);
        if (wr && off == 3'd1)
            opb_d = (opb_q & ~wmask[WIDTH-1:0]) | (wbs_dat_i[WIDTH-1:0] & wmask[WIDTH-1:0]);
        if (wr && off == 3'd2 && wbs_sel_i[0]) begin
            cin_d = wbs_dat_i[1];
            ie_d  = wbs_dat_i[2];
        end

        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        result_d = result_q;
        in_a_d   = in_a_q;
        in_b_d   = in_b_q;
        in_cin_d = in_cin_q;
        done_d   = done_q & ~(clr & wbs_dat_i[1]);
        err_d    = err_q  & ~(clr & wbs_dat_i[2]);

        // Completion and error setting come after W1C so a same-cycle set wins.
        case (state_q)
            IDLE: begin
                if (start) begin
                    in_a_d   = opa_q;
                    in_b_d   = opb_q;
                    in_cin_d = cin_d;
                    cnt_d    = CW'(LAT);
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (start)
                    err_d = 1'b1;
                if (cnt_q == '0) begin
                    result_d = sum_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cin_q    <= 1'b0;
            ie_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            in_a_q   <= '0;
            in_b_q   <= '0;
            in_cin_q <= 1'b0;
            g_q      <= '0;
            p_q      <= '0;
            x_q      <= '0;
            c_q      <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cin_q    <= cin_d;
            ie_q     <= ie_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            in_a_q   <= in_a_d;
            in_b_q   <= in_b_d;
            in_cin_q <= in_cin_d;
            g_q      <= g_d;
            p_q      <= p_d;
            x_q      <= x_d;
            c_q      <= c_d;
            sum_q    <= sum_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, BASE_ADR[4:0]};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = done_q & ie_q;
endmodule

// File: tb/tb_wb_ksa_responder.sv
// tb/tb_wb_ksa_responder.sv - directed self-checking bench for wb_ksa_responder
module tb_wb_ksa_responder;
    localparam int          W    = 16;
    localparam int          LAT  = $clog2(W) + 2;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_OPA = BASE + 32'h00, A_OPB = BASE + 32'h04, A_CTRL = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C, A_RES = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = 32'd0, adr = 32'd0;
    logic        ack, irq;
    logic [31:0] dat_o;

    int checks = 0;
    int passes = 0;

    wb_ksa_responder #(.BASE_ADR(BASE), .WIDTH(W), .LAT(LAT)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rstn),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output bit acked);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        acked = 1'b0; rd = 32'd0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        bit acked;
        wb_xfer(1'b1, a, d, 4'hF, rd, acked);
        if (!acked) check({tag, "_ack"}, 32'(acked), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bit acked;
        wb_xfer(1'b0, a, 32'd0, 4'hF, rd, acked);
        if (!acked) check({tag, "_ack"}, 32'(acked), 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] rd;
        bit acked;
        bit idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wb_xfer(1'b0, A_STAT, 32'd0, 4'hF, rd, acked);
            if (acked && rd[0] == 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    logic [31:0] rdv;
    bit          ackd;

    initial begin
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_status", A_STAT, 32'h0);
        rd_chk("rst_result", A_RES, 32'h0);

        wr("t1_opa", A_OPA, 32'h1234);
        wr("t1_opb", A_OPB, 32'h4321);
        wr("t1_ctrl", A_CTRL, 32'h1);
        rd_chk("t1_busy", A_STAT, 32'h1);
        wait_idle("t1");
        rd_chk("t1_status", A_STAT, 32'h2);
        rd_chk("t1_result", A_RES, 32'h05555);

        wr("t2_opa", A_OPA, 32'hFFFF);
        wr("t2_opb", A_OPB, 32'h0001);
        wr("t2_ctrl", A_CTRL, 32'h1);
        rd_chk("t2_busy_done_clr", A_STAT, 32'h1);
        wait_idle("t2");
        rd_chk("t2_result", A_RES, 32'h10000);

        wr("t3_opb", A_OPB, 32'h0000);
        wr("t3_ctrl", A_CTRL, 32'h3);
        rd_chk("t3_ctrl_rd", A_CTRL, 32'h2);
        wait_idle("t3");
        rd_chk("t3_result", A_RES, 32'h10000);

        wr("t4_opa", A_OPA, 32'h8000);
        wr("t4_opb", A_OPB, 32'h8000);
        wr("t4_ctrl", A_CTRL, 32'h5);
        check("t4_irq_low_busy", 32'(irq), 32'd0);
        wait_idle("t4");
        check("t4_irq_high", 32'(irq), 32'd1);
        rd_chk("t4_result", A_RES, 32'h10000);
        wr("t4_clr", A_STAT, 32'h2);
        check("t4_irq_cleared", 32'(irq), 32'd0);
        rd_chk("t4_status", A_STAT, 32'h0);

        wr("t5_opa", A_OPA, 32'h1111);
        wr("t5_opb", A_OPB, 32'h2222);
        wr("t5_ctrl", A_CTRL, 32'h1);
        wr("t5_opa2", A_OPA, 32'h5555);
        wr("t5_ctrl2", A_CTRL, 32'h1);
        wait_idle("t5");
        rd_chk("t5_status", A_STAT, 32'h6);
        rd_chk("t5_result", A_RES, 32'h03333);
        rd_chk("t5_opa_kept", A_OPA, 32'h5555);
        check("t5_irq", 32'(irq), 32'd0);

        wr("t6_ie", A_CTRL, 32'h4);
        wr("t6_ctrl", A_CTRL, 32'h5);
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        check("t6_irq", 32'(irq), 32'd0);
        rd_chk("t6_status", A_STAT, 32'h0);
        rd_chk("t6_result", A_RES, 32'h0);
        repeat (LAT + 4) @(posedge clk);
        #1;
        rd_chk("t6_no_done", A_STAT, 32'h0);
        check("t6_irq_late", 32'(irq), 32'd0);

        wr("t7_opa", A_OPA, 32'h1234);
        wb_xfer(1'b1, A_OPA, 32'hAABBCCDD, 4'b0001, rdv, ackd);
        check("t7_sel_ack", 32'(ackd), 32'd1);
        rd_chk("t7_opa_byte", A_OPA, 32'h000012DD);
        wb_xfer(1'b0, BASE + 32'h18, 32'd0, 4'hF, rdv, ackd);
        check("t7_off6_ack", 32'(ackd), 32'd1);
        check("t7_off6_dat", rdv, 32'd0);
        wb_xfer(1'b0, 32'h4000_0000, 32'd0, 4'hF, rdv, ackd);
        check("t7_miss_noack", 32'(ackd), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
